// File: rtl/acsi_pkg.sv
// acsi_pkg: FSM states, ICD escape and opcode constants shared by the ACSI initiator and target blocks.
package acsi_pkg;
  typedef enum logic [2:0] {IDLE, SEL_WR, GAP_WR, WAIT_IRQ, SEL_RD, GAP_RD, FIN} state_t;
  localparam logic [4:0] ICD_ESC = 5'h1F;
  localparam logic [7:0] ICD_MIN = 8'h20;
  localparam logic [7:0] OP_TEST_UNIT_READY = 8'h00;
  localparam logic [7:0] OP_REQUEST_SENSE = 8'h03;
  localparam logic [7:0] OP_READ6 = 8'h08;
  localparam logic [7:0] OP_WRITE6 = 8'h0A;
  localparam logic [7:0] OP_INQUIRY = 8'h12;
  localparam logic [7:0] OP_ICD = 8'h1F;
  localparam logic [4:0] LEN_MIN = 5'd6;
  localparam logic [4:0] LEN_MAX = 5'd16;
  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    return l < LEN_MIN ? LEN_MIN : (l > LEN_MAX ? LEN_MAX : l);
  endfunction
  // First bus byte: target id plus opcode, or the escape code when an ICD command follows.
  function automatic logic [7:0] hdr_byte(input logic [2:0] tgt, input logic icd, input logic [4:0] op);
    return {tgt, icd ? ICD_ESC : op};
  endfunction
endpackage

// File: rtl/acsi_initiator_if.sv
// acsi_initiator_if: host command port and ACSI bus signals of the initiator.
interface acsi_initiator_if;
  logic       cmd_wr;
  logic [3:0] cmd_wr_addr;
  logic [7:0] cmd_wr_data;
  logic [2:0] target;
  logic [4:0] cmd_len;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] status;
  logic       timeout;
  logic       bus_sel;
  logic       bus_rw;
  logic       bus_a1;
  logic [7:0] bus_dout;
  logic [7:0] bus_din;
  logic       irq;
  modport master (
    input  cmd_wr, cmd_wr_addr, cmd_wr_data, target, cmd_len, start, bus_din, irq,
    output busy, done, status, timeout, bus_sel, bus_rw, bus_a1, bus_dout
  );
  modport slave (
    output cmd_wr, cmd_wr_addr, cmd_wr_data, target, cmd_len, start, bus_din, irq,
    input  busy, done, status, timeout, bus_sel, bus_rw, bus_a1, bus_dout
  );
endinterface

// File: rtl/acsi_initiator.sv
// acsi_initiator: sends a buffered CDB byte by byte over ACSI, waiting for irq after each byte, then reads status.
module acsi_initiator
  import acsi_pkg::*;
#(
  parameter int          SEL_TICKS    = 2,
  parameter logic [23:0] BYTE_TIMEOUT = 24'd1000,
  parameter logic [23:0] CMD_TIMEOUT  = 24'hFFFFFF
) (
  input logic clk,
  input logic reset,
  input logic clk_en,
  acsi_initiator_if.master io
);
  localparam logic [23:0] SEL_CNT = 24'(SEL_TICKS - 1);
  logic [7:0]  r_buf [16];
  state_t      r_state;
  logic [2:0]  r_target;
  logic [4:0]  r_len;
  logic        r_icd;
  logic [4:0]  r_idx;
  logic [23:0] r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_status;
  logic        r_timeout;
  logic        r_sel;
  logic        r_rw;
  logic        r_a1;
  logic [7:0]  r_dout;
  logic        w_icd0;
  logic        w_last;
  logic [3:0]  w_buf_idx;
  assign w_icd0 = r_buf[0] >= ICD_MIN;
  assign w_last = r_idx == r_len + {4'd0, r_icd} - 5'd1;
  // Buffer slot of the next bus byte: the escape byte shifts the CDB up by one.
  assign w_buf_idx = 4'(r_idx + 5'd1 - {4'd0, r_icd});
  always_ff @(posedge clk)
    if (io.cmd_wr) r_buf[io.cmd_wr_addr] <= io.cmd_wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_target  <= '0;
      r_len     <= '0;
      r_icd     <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_status  <= '0;
      r_timeout <= 1'b0;
      r_sel     <= 1'b0;
      r_rw      <= 1'b1;
      r_a1      <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (io.start) begin
          r_target  <= io.target;
          r_len     <= clamp_len(io.cmd_len);
          r_icd     <= w_icd0;
          r_idx     <= '0;
          r_timeout <= 1'b0;
          r_busy    <= 1'b1;
          r_sel     <= 1'b1;
          r_rw      <= 1'b0;
          r_a1      <= 1'b0;
          r_dout    <= hdr_byte(io.target, w_icd0, r_buf[0][4:0]);
          r_cnt     <= SEL_CNT;
          r_state   <= SEL_WR;
        end
        SEL_WR: if (clk_en) begin
          if (r_cnt == '0) begin
            r_sel   <= 1'b0;
            r_rw    <= 1'b1;
            r_a1    <= 1'b0;
            r_dout  <= '0;
            r_state <= GAP_WR;
          end else r_cnt <= r_cnt - 24'd1;
        end
        GAP_WR: if (clk_en) begin
          r_cnt   <= w_last ? CMD_TIMEOUT : BYTE_TIMEOUT;
          r_state <= WAIT_IRQ;
        end
        WAIT_IRQ: if (clk_en) begin
          if (io.irq && !w_last) begin
            r_idx   <= r_idx + 5'd1;
            r_sel   <= 1'b1;
            r_rw    <= 1'b0;
            r_a1    <= 1'b1;
            r_dout  <= r_buf[w_buf_idx];
            r_cnt   <= SEL_CNT;
            r_state <= SEL_WR;
          end else if (io.irq) begin
            r_sel   <= 1'b1;
            r_rw    <= 1'b1;
            r_a1    <= 1'b0;
            r_cnt   <= SEL_CNT;
            r_state <= SEL_RD;
          end else if (r_cnt <= 24'd1) begin
            r_cnt     <= '0;
            r_timeout <= 1'b1;
            r_status  <= 8'hFF;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= FIN;
          end else r_cnt <= r_cnt - 24'd1;
        end
        SEL_RD: if (clk_en) begin
          if (r_cnt == '0) begin
            r_status <= io.bus_din;
            r_sel    <= 1'b0;
            r_state  <= GAP_RD;
          end else r_cnt <= r_cnt - 24'd1;
        end
        GAP_RD: if (clk_en) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= FIN;
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign io.busy     = r_busy;
  assign io.done     = r_done;
  assign io.status   = r_status;
  assign io.timeout  = r_timeout;
  assign io.bus_sel  = r_sel;
  assign io.bus_rw   = r_rw;
  assign io.bus_a1   = r_a1;
  assign io.bus_dout = r_dout;
endmodule

// File: tb/tb_acsi_initiator.sv
// tb_acsi_initiator: scoreboard bench with a target model that acks, stalls or holds irq.
module tb_acsi_initiator;
  localparam int S = 2;
  localparam int TB = 40;
  localparam int TC = 200;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;
  acsi_initiator_if io();
  acsi_initiator #(.SEL_TICKS(S), .BYTE_TIMEOUT(24'(TB)), .CMD_TIMEOUT(24'(TC))) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .io(io)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  logic [8:0] exp_q[$];
  logic [7:0] mb [16];
  int ticks = 0, writes_seen = 0, rd_cnt = 0, done_cnt = 0;
  int t0, w0, r0, d0, exp_n;
  int stop_at = -1;
  bit irq_hold = 0, irq_ack = 0, rand_en = 1, en_q = 0, busy_q = 0;
  logic prev_sel = 1'b0, prev_rw = 1'b1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: advance to the negedge, account the tick, run the target model, pick the next clk_en.
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    if (en_q && busy_q) ticks++;
    if (io.done) done_cnt++;
    if (io.bus_sel && !prev_sel) begin
      if (!io.bus_rw) begin
        writes_seen++;
        irq_ack = 0;
        if (exp_q.size() == 0) check("wr_extra", 32'(writes_seen - w0), 32'(exp_n));
        else begin
          e = exp_q.pop_front();
          check("wr_byte", {23'd0, io.bus_a1, io.bus_dout}, {23'd0, e});
        end
      end else rd_cnt++;
    end
    if (!io.bus_sel && prev_sel && !prev_rw && (stop_at < 0 || writes_seen - w0 <= stop_at)) irq_ack = 1;
    prev_sel = io.bus_sel;
    prev_rw = io.bus_rw;
    io.irq = irq_hold | irq_ack;
    busy_q = io.busy;
    clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    en_q = clk_en;
  endtask

  task automatic wr_buf(int a, int d);
    io.cmd_wr = 1'b1;
    io.cmd_wr_addr = 4'(a);
    io.cmd_wr_data = 8'(d);
    step();
    io.cmd_wr = 1'b0;
    mb[a] = 8'(d);
  endtask

  task automatic start_cmd(int tgt, int len, int oa, int ov);
    int l = len < 6 ? 6 : (len > 16 ? 16 : len);
    int icd = mb[0] >= 8'h20 ? 1 : 0;
    exp_q.delete();
    for (int n = 0; n < l + icd; n++)
      if (n == 0) exp_q.push_back({1'b0, 3'(tgt), icd != 0 ? 5'h1F : mb[0][4:0]});
      else exp_q.push_back({1'b1, (n - icd == oa) ? 8'(ov) : mb[n - icd]});
    exp_n = l + icd;
    t0 = ticks; w0 = writes_seen; r0 = rd_cnt; d0 = done_cnt;
    io.target = 3'(tgt);
    io.cmd_len = 5'(len);
    io.start = 1'b1;
    step();
    io.start = 1'b0;
    check("busy_start", {31'd0, io.busy}, 32'd1);
  endtask

  task automatic finish_cmd(int ew, int er, int et, int es, int eto);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin step(); n++; end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    check("busy_end", {31'd0, io.busy}, 32'd0);
    check("status", {24'd0, io.status}, 32'(es));
    check("timeout", {31'd0, io.timeout}, 32'(eto));
    check("ticks", 32'(ticks - t0), 32'(et));
    check("writes", 32'(writes_seen - w0), 32'(ew));
    check("reads", 32'(rd_cnt - r0), 32'(er));
    exp_q.delete();
    step();
    check("done_pulse", {31'd0, io.done}, 32'd0);
  endtask

  function automatic int ok_ticks(int nb);
    return nb * (S + 2) + S + 1;
  endfunction

  initial begin
    io.cmd_wr = 0; io.cmd_wr_addr = 0; io.cmd_wr_data = 0;
    io.target = 0; io.cmd_len = 6; io.start = 0; io.bus_din = 0; io.irq = 0;
    repeat (3) step();
    check("rst_busy", {31'd0, io.busy}, 32'd0);
    check("rst_done", {31'd0, io.done}, 32'd0);
    check("rst_timeout", {31'd0, io.timeout}, 32'd0);
    check("rst_status", {24'd0, io.status}, 32'd0);
    check("rst_bus", {20'd0, io.bus_sel, io.bus_rw, io.bus_a1, 1'b0, io.bus_dout}, 32'h400);
    reset = 0;
    step();
    for (int i = 0; i < 16; i++) wr_buf(i, 0);
    // all-zero six-byte command to target 1
    start_cmd(1, 6, -1, 0);
    finish_cmd(6, 1, ok_ticks(6), 8'h00, 0);
    // ICD command: escape byte then the full ten-byte CDB
    wr_buf(0, 8'h25);
    for (int i = 1; i < 16; i++) wr_buf(i, 8'(i * 17));
    io.bus_din = 8'h00;
    start_cmd(0, 10, -1, 0);
    finish_cmd(11, 1, ok_ticks(11), 8'h00, 0);
    // target stalls after byte 2
    stop_at = 2;
    start_cmd(3, 6, -1, 0);
    finish_cmd(3, 0, 2 * (S + 2) + S + 1 + TB, 8'hFF, 1);
    // stall on the final byte uses the long command timeout
    stop_at = 5;
    wr_buf(0, 8'h12);
    start_cmd(2, 6, -1, 0);
    finish_cmd(6, 0, 5 * (S + 2) + S + 1 + TC, 8'hFF, 1);
    stop_at = -1;
    // unsupported opcode, target reports check condition
    wr_buf(0, 8'h3E);
    io.bus_din = 8'h02;
    start_cmd(5, 6, -1, 0);
    finish_cmd(7, 1, ok_ticks(7), 8'h02, 0);
    // length clamping at both ends
    wr_buf(0, 8'h12);
    io.bus_din = 8'h5A;
    start_cmd(4, 3, -1, 0);
    finish_cmd(6, 1, ok_ticks(6), 8'h5A, 0);
    start_cmd(7, 20, -1, 0);
    finish_cmd(16, 1, ok_ticks(16), 8'h5A, 0);
    // buffer rewritten while busy: byte 6 not yet sent takes the new value
    io.bus_din = 8'h33;
    start_cmd(6, 8, 6, 8'hA5);
    for (int n = 0; n < 500 && writes_seen - w0 < 2; n++) step();
    wr_buf(6, 8'hA5);
    finish_cmd(8, 1, ok_ticks(8), 8'h33, 0);
    // irq held high throughout, second start while busy is ignored
    irq_hold = 1;
    start_cmd(1, 6, -1, 0);
    repeat (5) step();
    io.start = 1'b1;
    step();
    io.start = 1'b0;
    finish_cmd(6, 1, ok_ticks(6), 8'h33, 0);
    repeat (10) step();
    check("one_done", 32'(done_cnt - d0), 32'd1);
    check("idle_after", {31'd0, io.busy}, 32'd0);
    irq_hold = 0;
    // reset in the middle of byte 3
    start_cmd(3, 6, -1, 0);
    for (int n = 0; n < 500 && writes_seen - w0 < 4; n++) step();
    check("rst_reached", 32'(writes_seen - w0), 32'd4);
    reset = 1;
    step();
    check("rst_mid_sel", {31'd0, io.bus_sel}, 32'd0);
    check("rst_mid_busy", {31'd0, io.busy}, 32'd0);
    reset = 0;
    exp_q.delete();
    step();
    io.bus_din = 8'h00;
    start_cmd(3, 6, -1, 0);
    finish_cmd(6, 1, ok_ticks(6), 8'h00, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
